// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM encoding and default PC / instruction widths.
package instr_fetch_unit_pkg;

  localparam int unsigned DefAw = 32;
  localparam int unsigned DefDw = 32;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StDiscard = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Parametric synchronous FIFO with synchronous clear; the head entry is always visible on rdata_o.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = wdata_i;
        wptr_d        = wptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rptr_d = rptr_q + PtrW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues one instruction-memory read at a time and buffers {pc, instr} for decode.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = DefAw,
  parameter int unsigned DW    = DefDw
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc_in,
  input  logic          pc_valid,
  output logic          pc_ready,
  input  logic          flush,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_rdata,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [DW-1:0] instr_out,
  output logic [AW-1:0] instr_pc
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  fetch_state_e     state_q, state_d;
  logic [AW-1:0]    pend_pc_q, pend_pc_d;
  logic             fifo_push, fifo_pop;
  logic             fifo_full, fifo_empty;
  logic [CntW-1:0]  fifo_count;
  logic [AW+DW-1:0] fifo_rdata;

  // Gated by reset so the stage never advertises readiness while held in reset.
  assign pc_ready    = !reset && (state_q == StIdle) && (fifo_count < CntW'(DEPTH)) && !flush;
  assign imem_req    = (state_q != StIdle);
  assign imem_addr   = pend_pc_q;
  assign instr_valid = !fifo_empty;
  assign instr_pc    = fifo_rdata[AW+DW-1:DW];
  assign instr_out   = fifo_rdata[DW-1:0];
  assign fifo_pop    = instr_valid && instr_ready && !flush;

  always_comb begin
    state_d   = state_q;
    pend_pc_d = pend_pc_q;
    fifo_push = 1'b0;
    case (state_q)
      StIdle: begin
        if (pc_valid && pc_ready) begin
          state_d   = StReq;
          pend_pc_d = pc_in;
        end
      end
      StReq: begin
        if (imem_ack) begin
          state_d   = StIdle;
          fifo_push = !flush && !fifo_full;
        end else if (flush) begin
          // The memory cannot cancel a request: keep it up and drop the answer.
          state_d = StDiscard;
        end
      end
      StDiscard: begin
        if (imem_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(AW + DW)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .clear_i(flush),
    .push_i (fifo_push),
    .wdata_i({pend_pc_q, imem_rdata}),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised bench for instr_fetch_unit with a queue-based reference model and a negedge monitor.
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;

  logic          clk;
  logic          reset;
  logic [AW-1:0] pc_in;
  logic          pc_valid;
  logic          pc_ready;
  logic          flush;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [DW-1:0] imem_rdata;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr_out;
  logic [AW-1:0] instr_pc;

  instr_fetch_unit #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_in      (pc_in),
    .pc_valid   (pc_valid),
    .pc_ready   (pc_ready),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_out  (instr_out),
    .instr_pc   (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: instructions delivered are accepted PCs in order, minus any flushed.
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } entry_t;

  entry_t        exp_q[$];
  bit            outstanding = 1'b0;
  bit            discarding = 1'b0;
  logic [AW-1:0] out_pc = '0;

  always @(negedge clk) begin
    bit exp_ready;
    if (reset) begin
      exp_q.delete();
      outstanding = 1'b0;
      discarding  = 1'b0;
    end else begin
      check("instr_valid", 64'(instr_valid), 64'(exp_q.size() != 0));
      exp_ready = !outstanding && (exp_q.size() < DEPTH) && !flush;
      check("pc_ready", 64'(pc_ready), 64'(exp_ready));
      check("imem_req", 64'(imem_req), 64'(outstanding));
      if (outstanding) check("imem_addr", 64'(imem_addr), 64'(out_pc));
      if (instr_valid && instr_ready && !flush && exp_q.size() != 0) begin
        check("instr_pc", 64'(instr_pc), 64'(exp_q[0].pc));
        check("instr_out", 64'(instr_out), 64'(exp_q[0].instr));
      end
      if (flush) begin
        exp_q.delete();
        if (outstanding) begin
          if (imem_ack) outstanding = 1'b0;
          else discarding = 1'b1;
        end
      end else begin
        if (instr_valid && instr_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (outstanding && imem_ack) begin
          if (!discarding) exp_q.push_back('{pc: out_pc, instr: imem_rdata});
          outstanding = 1'b0;
          discarding  = 1'b0;
        end
      end
      if (!outstanding && pc_valid && exp_ready) begin
        outstanding = 1'b1;
        discarding  = 1'b0;
        out_pc      = pc_in;
      end
    end
  end

  // Instruction memory: acks a held request after lat cycles (never in the first request cycle).
  int            lat_lo = 1;
  int            lat_hi = 4;
  bit            data_ovr = 1'b0;
  logic [DW-1:0] ovr_data = '0;
  int            wait_cnt = -1;

  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        imem_ack = 1'b0;
        wait_cnt = -1;
      end else if (imem_ack) begin
        imem_ack = 1'b0;
      end else if (imem_req) begin
        if (wait_cnt < 0) begin
          wait_cnt = $urandom_range(lat_hi, lat_lo);
        end else begin
          wait_cnt--;
          if (wait_cnt == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = data_ovr ? ovr_data : DW'($urandom);
            wait_cnt   = -1;
          end
        end
      end
    end
  end

  task automatic issue(input logic [AW-1:0] pc);
    bit done = 1'b0;
    pc_valid = 1'b1;
    pc_in    = pc;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (pc_ready) done = 1'b1;
    end
    @(posedge clk);
    #2;
    pc_valid = 1'b0;
    if (!done) begin
      miscompares++;
      $display("FAIL issue_timeout: pc %0h never accepted", pc);
    end
  endtask

  task automatic wait_valid(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (instr_valid) done = 1'b1;
    end
    if (!done) begin
      miscompares++;
      $display("FAIL %s: instr_valid timeout", name);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    bit hit;
    reset       = 1'b1;
    pc_in       = '0;
    pc_valid    = 1'b0;
    flush       = 1'b0;
    instr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_imem_req", 64'(imem_req), 64'd0);
    check("rst_imem_addr", 64'(imem_addr), 64'd0);
    check("rst_pc_ready", 64'(pc_ready), 64'd0);
    check("rst_instr_valid", 64'(instr_valid), 64'd0);
    check("rst_instr_out", 64'(instr_out), 64'd0);
    check("rst_instr_pc", 64'(instr_pc), 64'd0);
    #1;
    reset = 1'b0;
    cycles(1);

    // Single fetch of PC 5, ack two cycles into the request.
    lat_lo = 2; lat_hi = 2; data_ovr = 1'b1; ovr_data = 32'hDEAD0005;
    instr_ready = 1'b1;
    issue(32'd5);
    wait_valid("s1");
    check("s1_instr_out", 64'(instr_out), 64'h0000_0000_DEAD_0005);
    check("s1_instr_pc", 64'(instr_pc), 64'd5);
    cycles(3);

    // Fill the FIFO with 1 and 2, then 3 waits until a pop frees a slot.
    data_ovr = 1'b0; lat_lo = 1; lat_hi = 3;
    instr_ready = 1'b0;
    issue(32'd1);
    issue(32'd2);
    pc_valid = 1'b1;
    pc_in    = 32'd3;
    cycles(10);
    @(negedge clk);
    check("s2_full_ready", 64'(pc_ready), 64'd0);
    check("s2_head_pc", 64'(instr_pc), 64'd1);
    @(posedge clk);
    #2;
    instr_ready = 1'b1;
    @(posedge clk);
    #2;
    instr_ready = 1'b0;
    issue(32'd3);
    instr_ready = 1'b1;
    cycles(12);

    // Flush while PC 7 is outstanding; its late 0xBAD answer must be dropped.
    lat_lo = 4; lat_hi = 4; data_ovr = 1'b1; ovr_data = 32'h0000_0BAD;
    issue(32'd7);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    cycles(8);
    check("s3_empty", 64'(instr_valid), 64'd0);

    // Flush in the same cycle as the ack, with one entry buffered.
    data_ovr = 1'b0; lat_lo = 3; lat_hi = 3;
    instr_ready = 1'b0;
    issue(32'd10);
    issue(32'd11);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge clk);
      #2;
      if (imem_ack) begin
        flush = 1'b1;
        hit   = 1'b1;
      end
    end
    @(posedge clk);
    #2;
    flush = 1'b0;
    @(negedge clk);
    check("s4_empty", 64'(instr_valid), 64'd0);
    check("s4_idle", 64'(imem_req), 64'd0);

    // Randomised traffic with an asynchronous reset dropped in the middle.
    lat_lo = 1; lat_hi = 4;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        pc_valid = 1'b1;
        pc_in    = $urandom;
        flush    = 1'b0;
        hit      = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
          @(posedge clk);
          if (imem_req) hit = 1'b1;
        end
        pc_valid = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        check("async_imem_req", 64'(imem_req), 64'd0);
        check("async_instr_valid", 64'(instr_valid), 64'd0);
        check("async_pc_ready", 64'(pc_ready), 64'd0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        cycles(1);
        lat_lo = 2; lat_hi = 2; data_ovr = 1'b1; ovr_data = 32'hDEAD0000;
        instr_ready = 1'b1;
        issue(32'd0);
        wait_valid("post_rst");
        check("post_rst_instr_out", 64'(instr_out), 64'h0000_0000_DEAD_0000);
        check("post_rst_instr_pc", 64'(instr_pc), 64'd0);
        data_ovr = 1'b0; lat_lo = 1; lat_hi = 4;
      end
      pc_valid    = ($urandom_range(0, 3) != 0);
      pc_in       = $urandom;
      flush       = ($urandom_range(0, 15) == 0);
      instr_ready = ($urandom_range(0, 3) != 0);
      cycles(1);
    end

    pc_valid    = 1'b0;
    flush       = 1'b0;
    instr_ready = 1'b1;
    cycles(20);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
